// File: rtl/test_status_reporter.sv
// Watches the tohost write path of a test program: prints console bytes, and on an
// exit write waits a short drain period before raising a sticky pass/fail verdict.
module test_status_reporter #(
    parameter int DATA_W          = 64,
    parameter int DRAIN_CYCLES    = 16,
    parameter int WATCHDOG_CYCLES = 0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              tohost_valid,
    output logic              tohost_ready,
    input  logic [DATA_W-1:0] tohost_data,
    output logic              console_valid,
    output logic [7:0]        console_char,
    output logic              success,
    output logic              failure,
    output logic [31:0]       exit_code,
    output logic              timeout,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_PASS  = 2'd2;
    localparam logic [1:0] ST_FAIL  = 2'd3;

    localparam int DR_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam int WD_W = (WATCHDOG_CYCLES < 2) ? 1 : $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [DR_W-1:0] DR_INIT = DR_W'(DRAIN_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = (WATCHDOG_CYCLES > 0) ? WD_W'(WATCHDOG_CYCLES - 1) : '0;

    logic [1:0]      r_state;
    logic [DR_W-1:0] r_drain_cnt;
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_console_valid;
    logic [7:0]      r_console_char;
    logic [31:0]     r_exit_code;
    logic            r_timeout;

    logic w_xfer;
    logic w_is_exit;
    logic w_is_console;
    logic w_wd_expire;
    logic w_unused_data;

    // Handshake: a write transfers on a rising edge where tohost_valid and
    // tohost_ready are both high; ready is only offered while running.
    assign tohost_ready = resetn && (r_state == ST_RUN);
    assign w_xfer       = tohost_valid && tohost_ready;
    assign w_is_exit    = tohost_data[0] && (tohost_data[63:48] == 16'h0000);
    assign w_is_console = (tohost_data[63:48] == 16'h0101);
    // Bits 47:33 and anything above 63 carry no meaning for this block.
    assign w_unused_data = ^tohost_data;

    assign w_wd_expire = (WATCHDOG_CYCLES != 0) && (r_state == ST_RUN) && !w_xfer
                         && (r_wd_cnt == WD_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state         <= ST_RUN;
            r_drain_cnt     <= '0;
            r_wd_cnt        <= '0;
            r_console_valid <= 1'b0;
            r_console_char  <= 8'h00;
            r_exit_code     <= 32'h0;
            r_timeout       <= 1'b0;
        end else begin
            r_console_valid <= w_xfer && w_is_console;
            if (w_xfer && w_is_console) begin
                r_console_char <= tohost_data[7:0];
            end
            case (r_state)
                ST_RUN: begin
                    if (w_xfer) begin
                        r_wd_cnt <= '0;
                        if (w_is_exit) begin
                            r_exit_code <= tohost_data[32:1];
                            r_drain_cnt <= DR_INIT;
                            r_state     <= ST_DRAIN;
                        end
                    end else if (w_wd_expire) begin
                        r_state     <= ST_FAIL;
                        r_timeout   <= 1'b1;
                        r_exit_code <= 32'hFFFF_FFFF;
                    end else if (WATCHDOG_CYCLES != 0) begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_state <= (r_exit_code == 32'h0) ? ST_PASS : ST_FAIL;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign console_valid = r_console_valid;
    assign console_char  = r_console_char;
    assign exit_code     = r_exit_code;
    assign timeout       = r_timeout;
    assign success       = (r_state == ST_PASS);
    assign failure       = (r_state == ST_FAIL);
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_test_status_reporter.sv
// Bench for test_status_reporter: three parameterisations driven from one stimulus
// process, with a deadline-based reference model feeding per-instance expected queues.
module tb_test_status_reporter;

    localparam int N_DUT = 3;

    typedef struct packed {
        logic        fail;
        logic        tmo;
        logic [31:0] code;
        logic [31:0] at;
    } res_t;

    logic        clock = 1'b0;
    logic        resetn [N_DUT];
    logic        tv     [N_DUT];
    logic [63:0] td     [N_DUT];
    logic        tr     [N_DUT];
    logic        cv     [N_DUT];
    logic [7:0]  cc     [N_DUT];
    logic        succ   [N_DUT];
    logic        fail   [N_DUT];
    logic [31:0] ec     [N_DUT];
    logic        tmo    [N_DUT];
    logic [1:0]  dbg    [N_DUT];

    logic [7:0] exp_char_q [N_DUT][$];
    res_t       exp_res_q  [N_DUT][$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int m_exit_at [N_DUT];
    int m_last    [N_DUT];
    bit m_tmo     [N_DUT];
    bit prev_done [N_DUT];

    always #5 clock = ~clock;

    test_status_reporter #(.DATA_W(64), .DRAIN_CYCLES(16), .WATCHDOG_CYCLES(0)) u_dut0 (
        .clock(clock), .resetn(resetn[0]), .tohost_valid(tv[0]), .tohost_ready(tr[0]),
        .tohost_data(td[0]), .console_valid(cv[0]), .console_char(cc[0]), .success(succ[0]),
        .failure(fail[0]), .exit_code(ec[0]), .timeout(tmo[0]), .dbg_state(dbg[0]));
    test_status_reporter #(.DATA_W(64), .DRAIN_CYCLES(0), .WATCHDOG_CYCLES(0)) u_dut1 (
        .clock(clock), .resetn(resetn[1]), .tohost_valid(tv[1]), .tohost_ready(tr[1]),
        .tohost_data(td[1]), .console_valid(cv[1]), .console_char(cc[1]), .success(succ[1]),
        .failure(fail[1]), .exit_code(ec[1]), .timeout(tmo[1]), .dbg_state(dbg[1]));
    test_status_reporter #(.DATA_W(64), .DRAIN_CYCLES(16), .WATCHDOG_CYCLES(100)) u_dut2 (
        .clock(clock), .resetn(resetn[2]), .tohost_valid(tv[2]), .tohost_ready(tr[2]),
        .tohost_data(td[2]), .console_valid(cv[2]), .console_char(cc[2]), .success(succ[2]),
        .failure(fail[2]), .exit_code(ec[2]), .timeout(tmo[2]), .dbg_state(dbg[2]));

    function automatic int drain_of(input int k);
        return (k == 1) ? 0 : 16;
    endfunction

    function automatic int wd_of(input int k);
        return (k == 2) ? 100 : 0;
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outs(input int k, input string tag);
        check_eq($sformatf("%s_ready[%0d]", tag, k), 64'(tr[k]), 64'd0);
        check_eq($sformatf("%s_console_valid[%0d]", tag, k), 64'(cv[k]), 64'd0);
        check_eq($sformatf("%s_console_char[%0d]", tag, k), 64'(cc[k]), 64'd0);
        check_eq($sformatf("%s_success[%0d]", tag, k), 64'(succ[k]), 64'd0);
        check_eq($sformatf("%s_failure[%0d]", tag, k), 64'(fail[k]), 64'd0);
        check_eq($sformatf("%s_timeout[%0d]", tag, k), 64'(tmo[k]), 64'd0);
        check_eq($sformatf("%s_exit_code[%0d]", tag, k), 64'(ec[k]), 64'd0);
    endtask

    // Monitor: pops expectations whenever a console pulse or a verdict appears.
    always @(negedge clock) begin
        logic [7:0] e_char;
        res_t       r;
        logic       done;
        for (int k = 0; k < N_DUT; k++) begin
            if (cv[k] === 1'b1) begin
                if (exp_char_q[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL console_unexpected[%0d]: got char %0h, expected no pulse (cycle %0d)",
                             k, cc[k], cyc);
                end else begin
                    e_char = exp_char_q[k].pop_front();
                    check_eq($sformatf("console_char[%0d]", k), 64'(cc[k]), 64'(e_char));
                end
            end
            done = succ[k] | fail[k];
            if (done && !prev_done[k]) begin
                if (exp_res_q[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL verdict_unexpected[%0d]: got success=%0b failure=%0b, expected none (cycle %0d)",
                             k, succ[k], fail[k], cyc);
                end else begin
                    r = exp_res_q[k].pop_front();
                    check_eq($sformatf("failure[%0d]", k), 64'(fail[k]), 64'(r.fail));
                    check_eq($sformatf("success[%0d]", k), 64'(succ[k]), 64'(!r.fail));
                    check_eq($sformatf("timeout[%0d]", k), 64'(tmo[k]), 64'(r.tmo));
                    check_eq($sformatf("exit_code[%0d]", k), 64'(ec[k]), 64'(r.code));
                    check_eq($sformatf("verdict_cycle[%0d]", k), 64'(cyc), 64'(r.at));
                end
            end
            if (succ[k] === 1'b1 && fail[k] === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL both_verdicts[%0d]: got success=1 failure=1, expected at most one", k);
            end
            if (prev_done[k] && !done && resetn[k] === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL verdict_dropped[%0d]: got 0, expected sticky 1 (cycle %0d)", k, cyc);
            end
            prev_done[k] = done;
        end
    end

    // One clock: evaluate the model for the coming edge, then land at negedge+2.
    task automatic step();
        int   e;
        logic rdy;
        res_t r;
        #1;
        e = cyc + 1;
        for (int k = 0; k < N_DUT; k++) begin
            if (resetn[k] !== 1'b1) begin
                m_last[k] = e;
                check_eq($sformatf("ready_in_reset[%0d]", k), 64'(tr[k]), 64'd0);
            end else begin
                rdy = (m_exit_at[k] < 0) && !m_tmo[k];
                check_eq($sformatf("ready[%0d]", k), 64'(tr[k]), 64'(rdy));
                if (rdy && tv[k]) begin
                    m_last[k] = e;
                    if (td[k][0] && td[k][63:48] == 16'h0000) begin
                        m_exit_at[k] = e;
                        r.fail = (td[k][32:1] != 32'h0);
                        r.tmo  = 1'b0;
                        r.code = td[k][32:1];
                        r.at   = 32'(e + 1 + drain_of(k));
                        exp_res_q[k].push_back(r);
                    end else if (td[k][63:48] == 16'h0101) begin
                        exp_char_q[k].push_back(td[k][7:0]);
                    end
                end else if (rdy && wd_of(k) != 0 && (e - m_last[k]) == wd_of(k)) begin
                    m_tmo[k] = 1'b1;
                    r.fail = 1'b1;
                    r.tmo  = 1'b1;
                    r.code = 32'hFFFF_FFFF;
                    r.at   = 32'(e);
                    exp_res_q[k].push_back(r);
                end
            end
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
        #2;
    endtask

    task automatic model_clear(input int k);
        exp_char_q[k].delete();
        exp_res_q[k].delete();
        m_exit_at[k] = -1;
        m_tmo[k]     = 1'b0;
    endtask

    task automatic do_reset(input int k);
        resetn[k] = 1'b0;
        tv[k]     = 1'b0;
        #1;
        check_reset_outs(k, "async_reset");
        model_clear(k);
        step();
        step();
        resetn[k] = 1'b1;
    endtask

    task automatic park(input int k);
        resetn[k] = 1'b0;
        tv[k]     = 1'b0;
        model_clear(k);
        step();
    endtask

    task automatic write1(input int k, input logic [63:0] data);
        tv[k] = 1'b1;
        td[k] = data;
        step();
        tv[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int n;
        n = 0;
        while ((exp_res_q[k].size() != 0 || exp_char_q[k].size() != 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (exp_res_q[k].size() != 0 || exp_char_q[k].size() != 0) begin
            errors++;
            $display("FAIL wait_budget[%0d]: got %0d pending outputs after %0d cycles, expected 0",
                     k, exp_res_q[k].size() + exp_char_q[k].size(), budget);
            exp_res_q[k].delete();
            exp_char_q[k].delete();
        end
    endtask

    function automatic logic [63:0] rand_data();
        int unsigned kind;
        logic [31:0] code;
        kind = $urandom_range(0, 7);
        if (kind == 0) begin
            code = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'($urandom_range(1, 255));
            return {16'h0000, 15'($urandom), code, 1'b1};
        end else if (kind <= 3) begin
            return {16'h0101, 16'($urandom), 32'($urandom)};
        end else if (kind <= 5) begin
            return {16'h0000, 16'($urandom), 31'($urandom), 1'b0};
        end
        return {1'b1, 15'($urandom), 16'($urandom), 32'($urandom)};
    endfunction

    initial begin
        for (int k = 0; k < N_DUT; k++) begin
            resetn[k] = 1'b0;
            tv[k]     = 1'b0;
            td[k]     = 64'h0;
            m_last[k] = 0;
            prev_done[k] = 1'b0;
            model_clear(k);
        end
        #3;
        for (int k = 0; k < N_DUT; k++) check_reset_outs(k, "power_on");
        @(negedge clock);
        #2;
        step();
        step();

        // Passing exit, then writes stay back-pressured
        resetn[0] = 1'b1;
        write1(0, 64'h1);
        wait_done(0, 40);
        tv[0] = 1'b1;
        td[0] = 64'h1;
        repeat (3) step();
        tv[0] = 1'b0;

        // Failing exit with code 3
        do_reset(0);
        write1(0, 64'h7);
        check_eq("exit_code_at_accept", 64'(ec[0]), 64'd3);
        wait_done(0, 40);
        tv[0] = 1'b1;
        td[0] = 64'h0101_0000_0000_0055;
        repeat (3) step();
        tv[0] = 1'b0;

        // Back-to-back console bytes
        do_reset(0);
        tv[0] = 1'b1;
        td[0] = 64'h0101_0000_0000_0041;
        step();
        td[0] = 64'h0101_0000_0000_0042;
        step();
        tv[0] = 1'b0;
        step();
        check_eq("console_char_hold", 64'(cc[0]), 64'h42);
        wait_done(0, 10);

        // Reset in the middle of a drain, then a fresh exit
        write1(0, 64'h1);
        repeat (11) step();
        do_reset(0);
        repeat (30) step();
        write1(0, 64'h1);
        wait_done(0, 40);
        park(0);

        // Zero-length drain
        resetn[1] = 1'b1;
        write1(1, 64'h1);
        wait_done(1, 5);
        do_reset(1);
        write1(1, 64'hB);
        wait_done(1, 5);
        park(1);

        // Watchdog expiry, then a console write landing on the expiry cycle
        resetn[2] = 1'b1;
        repeat (105) step();
        wait_done(2, 5);
        check_eq("timeout_ready_low", 64'(tr[2]), 64'd0);
        do_reset(2);
        repeat (99) step();
        write1(2, 64'h0101_0000_0000_005A);
        repeat (20) step();
        check_eq("watchdog_cleared_ready", 64'(tr[2]), 64'd1);
        write1(2, 64'h1);
        wait_done(2, 40);
        park(2);

        // Randomized segments on the 16-cycle drain instances
        for (int seg = 0; seg < 12; seg++) begin
            int k;
            int len;
            k   = (seg % 2 == 0) ? 0 : 2;
            len = (k == 0) ? 60 : 150;
            do_reset(k);
            for (int i = 0; i < len && m_exit_at[k] < 0 && !m_tmo[k]; i++) begin
                tv[k] = (k == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 59) == 0);
                td[k] = rand_data();
                step();
            end
            tv[k] = 1'b0;
            wait_done(k, 200);
            park(k);
        end

        for (int k = 0; k < N_DUT; k++) begin
            check_eq($sformatf("leftover_outputs[%0d]", k),
                     64'(exp_res_q[k].size() + exp_char_q[k].size()), 64'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/test_status_reporter.md
TEST_STATUS_REPORTER -- requirements
Module: test_status_reporter

Interface
REQ-001 DATA_W, 64, width of tohost write data; SHALL be >= 64.
REQ-002 DRAIN_CYCLES, 16, cycles between accepting an exit write and asserting success/failure (lets console output flush).
REQ-003 WATCHDOG_CYCLES, 0, RUN cycles with no accepted write before timeout failure; 0 SHALL disable the watchdog.
REQ-004 clock  input  1  sole clock; all state updates on posedge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 tohost_valid  input  1  write request from the DUT's tohost path.
REQ-007 tohost_ready  output  1  block can accept a write.
REQ-008 tohost_data  input  DATA_W  write payload.
REQ-009 console_valid  output  1  one-cycle pulse qualifying console_char.
REQ-010 console_char  output  8  decoded console byte.
REQ-011 success  output  1  sticky, test passed; consumed by the test driver.
REQ-012 failure  output  1  sticky, test failed.
REQ-013 exit_code  output  32  latched exit code.
REQ-014 timeout  output  1  sticky, failure caused by the watchdog.

Function
REQ-015 States SHALL be RUN, DRAIN, PASS, FAIL; PASS and FAIL are terminal until reset.
REQ-016 tohost_ready SHALL be 1 only in RUN with resetn high (combinational from state); transfer = tohost_valid && tohost_ready on a rising edge.
REQ-017 Exit write: data[0]==1 and data[63:48]==0; code = data[32:1]; higher bits are ignored.
REQ-018 Console write: data[63:56]==8'h01 and data[55:48]==8'h01; char = data[7:0].
REQ-019 Any other accepted write SHALL be consumed with no effect except clearing the watchdog.
REQ-020 Console transfer at edge N: console_valid=1, console_char=char during cycle N..N+1 only; back-to-back transfers SHALL give back-to-back pulses; console_char holds its last value otherwise.
REQ-021 Exit transfer at edge N: exit_code updated at N, state -> DRAIN, drain counter loaded with DRAIN_CYCLES.
REQ-022 In DRAIN, each edge: if counter==0 go to PASS (exit_code==0) or FAIL (nonzero), else decrement; success/failure SHALL be visible after edge N+1+DRAIN_CYCLES (DRAIN_CYCLES=0 gives 1 cycle).
REQ-023 success and failure SHALL be registered state decodes, never both 1, never deasserted except by reset.
REQ-024 Watchdog counter SHALL count RUN cycles since reset release or the last transfer, clear on any transfer, freeze outside RUN, and be sized to hold WATCHDOG_CYCLES without wrap.
REQ-025 When the counter reaches WATCHDOG_CYCLES-1 with no transfer that cycle: FAIL, timeout=1, exit_code=32'hFFFF_FFFF at the same edge.
REQ-026 A transfer in the expiry cycle SHALL win: the watchdog clears and the write is processed normally.
REQ-027 Writes presented in DRAIN/PASS/FAIL SHALL be back-pressured (ready=0), never dropped silently.

Reset
REQ-028 resetn low SHALL immediately force state RUN, success=0, failure=0, timeout=0, console_valid=0, console_char=0, exit_code=0, both counters 0, tohost_ready=0.
REQ-029 Reset asserted in any state, including mid-DRAIN, SHALL abort it; no success/failure SHALL assert afterward until a new exit write.
REQ-030 First transfer possible on the first rising edge after resetn rises.

Verification
REQ-031 DRAIN_CYCLES=16; write 64'h1 at edge N -> exit_code=0, success=1 from N+17, failure=0, ready=0 from N.
REQ-032 Write 64'h7 (code 3) -> after drain failure=1, exit_code=3, success=0; further tohost_valid stays unaccepted.
REQ-033 Writes 64'h0101_0000_0000_0041 then ..._0042 on consecutive edges -> console_valid high two cycles, chars 8'h41, 8'h42; state stays RUN.
REQ-034 WATCHDOG_CYCLES=100, no writes -> failure=1, timeout=1, exit_code=32'hFFFF_FFFF after 100 RUN cycles; repeat with a console write on the expiry cycle -> no timeout, counter cleared.
REQ-035 Exit write, then resetn low for 2 cycles at DRAIN count 5 -> all outputs 0 immediately, no success afterward; new 64'h1 write passes normally.
REQ-036 DRAIN_CYCLES=0; 64'h1 at edge N -> success=1 after edge N+1.
